vga_mem_sequencer: RTL and testbench

- Memory-side responder for the pixel generator's fetch interface.
- Drives pixel_state and serves vga_addr requests from the shared single-port text/glyph RAM.
- Returns vga_data on a fixed 4-clock-per-pixel slot schedule.
- Gives the leftover RAM slots to a CPU request/acknowledge port, so software can write characters and glyphs while video runs.

---
 rtl/vga_pkg.sv | 12 +
 rtl/vga_cpu_port.sv | 53 +++++
 rtl/vga_mem_sequencer.sv | 85 ++++++++
 tb/tb_vga_mem_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: phase encodings and default widths shared by the VGA memory sequencer
package vga_pkg;
    typedef enum logic [1:0] {
        PH_CHAR  = 2'd0,
        PH_GLYPH = 2'd1,
        PH_CPU   = 2'd2,
        PH_IDLE  = 2'd3
    } phase_t;
    localparam int CLKS_PER_PIXEL = 4;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 16;
endpackage

// File: rtl/vga_cpu_port.sv
// vga_cpu_port: CPU slot grant, single in-flight pending access, ack pulse and read data.
// Optional macro VGA_CPU_BLANK_EN also opens phases 0 and 1 to the CPU while active is low.
module vga_cpu_port
    import vga_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        phase,
    input  logic              active,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant,
    output logic              cpu_busy,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata
);
    logic              pending_q;
    logic              pend_we_q;
    logic              slot;
    logic [DATA_W-1:0] rdata_q;

`ifdef VGA_CPU_BLANK_EN
    assign slot     = (phase == PH_CPU) || (!active && (phase == PH_CHAR || phase == PH_GLYPH));
    // mem_rdata belongs to the CPU in an ack cycle; a blanking grant also pre-empts the video capture
    assign cpu_busy = (grant && !active) || (pending_q && phase != PH_IDLE);
`else
    logic unused_active;
    assign unused_active = active;
    assign slot          = phase == PH_CPU;
    assign cpu_busy      = 1'b0;
`endif

    // a pending access blocks new grants, so the ack always lands the cycle after its grant
    assign grant     = slot && cpu_req && !pending_q;
    assign cpu_ack   = pending_q;
    assign cpu_rdata = (pending_q && !pend_we_q) ? mem_rdata : rdata_q;

    // pending flag, access direction and held read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            pend_we_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            pending_q <= grant;
            if (grant) pend_we_q <= cpu_we;
            if (pending_q && !pend_we_q) rdata_q <= mem_rdata;
        end
    end
endmodule

// File: rtl/vga_mem_sequencer.sv
// vga_mem_sequencer: 4-phase RAM slot sequencer serving pixel fetches and a CPU port.
// Optional macro VGA_CPU_BLANK_EN adds CPU slots in phases 0/1 during blanking.
module vga_mem_sequencer
    import vga_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [1:0]        pixel_state,
    output logic [DATA_W-1:0] vga_data,
    output logic              pix_tick,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    phase_t            phase_q;
    phase_t            phase_d;
    logic [DATA_W-1:0] vga_data_q;
    logic              grant;
    logic              cpu_busy;
    logic              fetch_phase;

    vga_cpu_port #(.DATA_W(DATA_W)) u_cpu_port (
        .clk       (clk),
        .rst_n     (rst_n),
        .phase     (phase_q),
        .active    (active),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .mem_rdata (mem_rdata),
        .grant     (grant),
        .cpu_busy  (cpu_busy),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata)
    );

    assign pixel_state = phase_q;
    assign pix_tick    = phase_q == PH_IDLE;
    assign fetch_phase = phase_q == PH_GLYPH || phase_q == PH_CPU;
    assign vga_data    = fetch_phase ? mem_rdata : vga_data_q;

    // phase counter register; it never stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_q <= PH_CHAR;
        else        phase_q <= phase_d;
    end

    // free-running wrap 3 -> 0
    always_comb begin
        phase_d = phase_t'(phase_q + 2'd1);
    end

    // RAM port mux; forced to zero while reset is asserted
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (rst_n) begin
            if (grant) begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
            end else if (phase_q == PH_CHAR || phase_q == PH_GLYPH) begin
                mem_addr = vga_addr;
            end
        end
    end

    // hold the last video word for the phases where the RAM output is not video data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      vga_data_q <= '0;
        else if (fetch_phase && !cpu_busy) vga_data_q <= mem_rdata;
    end
endmodule

// File: tb/tb_vga_mem_sequencer.sv
// tb_vga_mem_sequencer: directed checks of phase sequencing, video fetch and CPU port
module tb_vga_mem_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        active;
    logic [15:0] vga_addr;
    logic [1:0]  pixel_state;
    logic [15:0] vga_data;
    logic        pix_tick;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic [15:0] ram [0:1023] = '{default: 16'h0};
    int          total = 0;
    int          bad = 0;

    vga_mem_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .active      (active),
        .vga_addr    (vga_addr),
        .pixel_state (pixel_state),
        .vga_data    (vga_data),
        .pix_tick    (pix_tick),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // single-port synchronous RAM, read data one clock after the address; preloaded during reset
    always @(posedge clk) begin
        if (!rst_n) begin
            ram[10'h040] <= 16'h4142;
            ram[10'h208] <= 16'h3C00;
        end else if (mem_we) begin
            ram[mem_addr[9:0]] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr[9:0]];
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; active = 1'b1; vga_addr = 16'h1234;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        tick; tick;
        chk("rst_state", pixel_state, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_vga_data", vga_data, 0);
        chk("rst_pix_tick", pix_tick, 0);
        chk("rst_ack", cpu_ack, 0);
        // release and watch the phase sequence
        rst_n = 1'b1;
        #1;
        chk("seq_state0", pixel_state, 0);
        chk("seq_tick0", pix_tick, 0);
        for (int i = 1; i <= 4; i++) begin
            tick;
            chk($sformatf("seq_state%0d", i), pixel_state, i % 4);
            chk($sformatf("seq_tick%0d", i), pix_tick, (i % 4) == 3);
        end
        // video fetch: char word then glyph word, glyph held through phases 3 and 0
        vga_addr = 16'h0040;
        #1;
        chk("vid_addr0", mem_addr, 16'h0040);
        chk("vid_we0", mem_we, 0);
        tick;
        chk("vid_char", vga_data, 16'h4142);
        vga_addr = 16'h0208;
        #1;
        chk("vid_addr1", mem_addr, 16'h0208);
        tick;
        chk("vid_glyph", vga_data, 16'h3C00);
        chk("vid_cpu_addr_idle", mem_addr, 0);
        tick;
        chk("vid_hold3", vga_data, 16'h3C00);
        tick;
        chk("vid_hold0", vga_data, 16'h3C00);
        // CPU write raised in phase 0
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'hBEEF;
        #1;
        chk("wr_we_ph0", mem_we, 0);
        tick;
        chk("wr_we_ph1", mem_we, 0);
        chk("wr_ack_ph1", cpu_ack, 0);
        tick;
        chk("wr_we_ph2", mem_we, 1);
        chk("wr_addr_ph2", mem_addr, 16'h0100);
        chk("wr_data_ph2", mem_wdata, 16'hBEEF);
        chk("wr_ack_ph2", cpu_ack, 0);
        tick;
        chk("wr_ack_ph3", cpu_ack, 1);
        chk("wr_we_ph3", mem_we, 0);
        cpu_req = 1'b0;
        tick;
        chk("wr_ack_ph0", cpu_ack, 0);
        chk("wr_rdata_kept", cpu_rdata, 0);
        chk("wr_ram", ram[10'h100], 16'hBEEF);
        // CPU read raised in phase 3: ack in the next phase 3, then again 4 clocks later
        tick; tick; tick;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
        #1;
        chk("rd_ack_start", cpu_ack, 0);
        for (int i = 1; i <= 8; i++) begin
            tick;
            chk($sformatf("rd_ack_c%0d", i), cpu_ack, (i % 4) == 0);
            if (i % 4 == 2) chk($sformatf("rd_we_c%0d", i), mem_we, 0);
            if (i >= 4) chk($sformatf("rd_data_c%0d", i), cpu_rdata, 16'hBEEF);
        end
        cpu_req = 1'b0;
        tick;
        // no request: no writes, no acks, video reads undisturbed
        for (int i = 0; i < 8; i++) begin
            vga_addr = (i % 4 == 0) ? 16'h0040 : 16'h0208;
            #1;
            chk($sformatf("idle_state%0d", i), pixel_state, i % 4);
            chk($sformatf("idle_we%0d", i), mem_we, 0);
            chk($sformatf("idle_ack%0d", i), cpu_ack, 0);
            if (i % 4 == 1) chk($sformatf("idle_char%0d", i), vga_data, 16'h4142);
            if (i % 4 == 2) chk($sformatf("idle_glyph%0d", i), vga_data, 16'h3C00);
            tick;
        end
        // blanking with back-to-back reads
        active = 1'b0; vga_addr = 16'h0040;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
        #1;
        for (int i = 0; i < 8; i++) begin
`ifdef VGA_CPU_BLANK_EN
            chk($sformatf("blank_ack%0d", i), cpu_ack, i % 2);
            if (i % 2 == 1) chk($sformatf("blank_rdata%0d", i), cpu_rdata, 16'hBEEF);
            if (i % 4 == 3 || i % 4 == 0) chk($sformatf("blank_hold%0d", i), vga_data, 16'h3C00);
`else
            chk($sformatf("blank_ack%0d", i), cpu_ack, (i % 4) == 3);
`endif
            tick;
        end
        cpu_req = 1'b0; active = 1'b1;
        tick; tick;
        // reset in the middle of a phase-2 write grant
        chk("mid_state", pixel_state, 2);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 16'h5555;
        #1;
        chk("mid_we_before", mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", pixel_state, 0);
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        chk("mid_rst_vga", vga_data, 0);
        chk("mid_rst_rdata", cpu_rdata, 0);
        chk("mid_rst_ack", cpu_ack, 0);
        chk("mid_rst_tick", pix_tick, 0);
        cpu_req = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("abandon_ack%0d", i), cpu_ack, 0);
        end
        chk("abandon_ram", ram[10'h300], 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
